pkt_receiver: RTL and testbench
===============================

// Module: pkt_receiver
// PURPOSE
//  Receive-side counterpart of the kernel's TCP transmit path. Takes TCP stack
//  rx notifications and issues read requests, one message at a time, for non-empty
//  notifications. Merges rx metadata and rx data into one internal packet stream
//  {len, session, tlast, tdata}, the same format the kernel's sender consumes.
//  Sits between the 100G TCP/IP stack rx interfaces and the top-k user logic.
// PARAMETERS
//  (none) widths fixed by the stack: 512b data, 16b session, 16b length
// PORTS
//  clk                          in   1    clock; all logic on rising edge
//  rst                          in   1    synchronous, active-high reset
//  s_axis_notifications_TDATA   in   88   [15:0] session, [31:16] length B, [80] closed
//  s_axis_notifications_TVALID  in   1
//  s_axis_notifications_TREADY  out  1
//  m_axis_read_package_TDATA    out  32   [15:0] session, [31:16] length B
//  m_axis_read_package_TVALID   out  1
//  m_axis_read_package_TREADY   in   1
//  s_axis_rx_metadata_TDATA     in   16   session of following data
//  s_axis_rx_metadata_TVALID    in   1
//  s_axis_rx_metadata_TREADY    out  1
//  s_axis_rx_data_TDATA         in   512
//  s_axis_rx_data_TKEEP         in   64
//  s_axis_rx_data_TLAST         in   1
//  s_axis_rx_data_TVALID        in   1
//  s_axis_rx_data_TREADY        out  1
//  pkt_tx_TDATA                 out  545  [544:529] len, [528:513] session, [512] tlast, [511:0] data
//  pkt_tx_TVALID                out  1
//  pkt_tx_TREADY                in   1
//  pkt_count                    out  32   messages fully forwarded (tlast beats out)
//  drop_count                   out  32   notifications discarded
//  err_flags                    out  2    sticky: [0] session mismatch, [1] partial TKEEP on non-last beat
// BEHAVIOUR
//  Reset: all TVALID/TREADY outputs 0, FSM=IDLE, counters 0, err_flags 0, output buffer empty.
//  FSM IDLE:
//   - notifications_TREADY=1.
//   - On accept with length==0 or closed==1: drop_count+=1, stay IDLE.
//   - Otherwise latch session/len, go REQ.
//  FSM REQ:
//   - read_package_TVALID=1 with {len,session}, held stable until TREADY.
//   - On handshake go META. Request appears the cycle after notification accept.
//  FSM META:
//   - rx_metadata_TREADY=1; on handshake go DATA.
//   - If value != latched session, set err_flags[0]; the latched session is still used downstream.
//  FSM DATA:
//   - rx_data_TREADY = output buffer can accept (2-entry skid, full throughput).
//   - Each beat forwarded as {len,session,TLAST,TDATA}; TKEEP is not forwarded.
//   - TKEEP!=all-ones with TLAST=0 sets err_flags[1].
//   - Beat with TLAST accepted -> IDLE. Next notification can be accepted that same following cycle.
//  Output stage:
//   - Registered, latency 1 cycle from rx_data handshake to pkt_tx_TVALID.
//   - TDATA stable while TVALID && !TREADY. No bubbles when TREADY held high.
//  Counters:
//   - pkt_count increments on pkt_tx handshake with tlast=1.
//   - Both counters wrap modulo 2^32.
//  Only one message in flight; notifications backpressured outside IDLE.
//  rst mid-message: FSM, buffer and counters cleared immediately. Stack-side partial data is not drained.
//   Recovery is by stack reset.
// TESTING
//  1. notif {sess=5,len=128}, meta=5, 2 beats (last on 2nd) -> read_pkg 0x00800005 once;
//     2 out beats with [544:513]=0x00800005, tlast on 2nd; pkt_count=1.
//  2. notif len=0, then notif closed=1 -> no read_pkg, drop_count=2, FSM stays IDLE.
//  3. pkt_tx_TREADY toggled 1010... over 8-beat message -> all 8 beats out in order, none lost or duplicated.
//     rx_data stalls only when buffer is full.
//  4. meta=7 after request for sess=5 -> err_flags=01; output session field = 5.
//  5. non-last beat TKEEP=0x0F..F -> err_flags[1]=1. Last beat with partial keep -> no flag.
//  6. rst asserted during beat 3 of 6 -> next cycle all VALIDs 0, counters 0.
//     A new notification is then processed normally.

Source files
------------

// File: rtl/pkt_receiver.sv
// pkt_receiver
//   Takes TCP stack rx notifications and issues one read request per
//   non-empty, open notification. It then merges the rx metadata and rx data of
//   that message into the internal packet stream {len, session, tlast, tdata}.
//   Only one message is in flight at a time.
// Ports
//   clk, rst                   clock; synchronous active-high reset
//   s_axis_notifications_*     notification in: [15:0] session, [31:16] len, [80] closed
//   m_axis_read_package_*      read request out: [15:0] session, [31:16] len
//   s_axis_rx_metadata_*       session tag preceding the rx data
//   s_axis_rx_data_*           512b rx data beats with TKEEP/TLAST
//   pkt_tx_*                   545b packet beats: [544:529] len, [528:513] session,
//                              [512] tlast, [511:0] data
//   pkt_count                  messages fully forwarded (tlast handshakes out)
//   drop_count                 notifications discarded (len==0 or closed)
//   err_flags                  sticky: [0] metadata session mismatch,
//                              [1] partial TKEEP on a non-last beat
module pkt_receiver (
    input  logic         clk,
    input  logic         rst,
    input  logic [87:0]  s_axis_notifications_TDATA,
    input  logic         s_axis_notifications_TVALID,
    output logic         s_axis_notifications_TREADY,
    output logic [31:0]  m_axis_read_package_TDATA,
    output logic         m_axis_read_package_TVALID,
    input  logic         m_axis_read_package_TREADY,
    input  logic [15:0]  s_axis_rx_metadata_TDATA,
    input  logic         s_axis_rx_metadata_TVALID,
    output logic         s_axis_rx_metadata_TREADY,
    input  logic [511:0] s_axis_rx_data_TDATA,
    input  logic [63:0]  s_axis_rx_data_TKEEP,
    input  logic         s_axis_rx_data_TLAST,
    input  logic         s_axis_rx_data_TVALID,
    output logic         s_axis_rx_data_TREADY,
    output logic [544:0] pkt_tx_TDATA,
    output logic         pkt_tx_TVALID,
    input  logic         pkt_tx_TREADY,
    output logic [31:0]  pkt_count,
    output logic [31:0]  drop_count,
    output logic [1:0]   err_flags
);

    typedef enum logic [1:0] {IDLE, REQ, META, DATA} state_t;

    state_t      state;
    logic [15:0] cur_sess;
    logic [15:0] cur_len;

    logic [15:0] notif_sess;
    logic [15:0] notif_len;
    logic        notif_closed;
    logic        unused_notif;

    assign notif_sess   = s_axis_notifications_TDATA[15:0];
    assign notif_len    = s_axis_notifications_TDATA[31:16];
    assign notif_closed = s_axis_notifications_TDATA[80];
    assign unused_notif = ^{s_axis_notifications_TDATA[87:81],
                            s_axis_notifications_TDATA[79:32]};

    // Output buffer: head register driving pkt_tx plus one skid entry.
    logic         skid_vld;
    logic [544:0] skid_data;

    logic in_fire;
    logic out_fire;

    // Ready depends only on registered state, so the stack sees no
    // combinational path from pkt_tx_TREADY.
    assign s_axis_rx_data_TREADY = (state == DATA) && !skid_vld;
    assign in_fire  = s_axis_rx_data_TVALID && s_axis_rx_data_TREADY;
    assign out_fire = pkt_tx_TVALID && pkt_tx_TREADY;

    logic [544:0] in_beat;
    assign in_beat = {cur_len, cur_sess, s_axis_rx_data_TLAST, s_axis_rx_data_TDATA};

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                       <= IDLE;
            cur_sess                    <= '0;
            cur_len                     <= '0;
            s_axis_notifications_TREADY <= 1'b0;
            m_axis_read_package_TVALID  <= 1'b0;
            m_axis_read_package_TDATA   <= '0;
            s_axis_rx_metadata_TREADY   <= 1'b0;
            drop_count                  <= '0;
            err_flags                   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_axis_notifications_TREADY <= 1'b1;
                    if (s_axis_notifications_TVALID && s_axis_notifications_TREADY) begin
                        if (notif_len == 16'd0 || notif_closed) begin
                            drop_count <= drop_count + 32'd1;
                        end else begin
                            cur_sess                    <= notif_sess;
                            cur_len                     <= notif_len;
                            s_axis_notifications_TREADY <= 1'b0;
                            m_axis_read_package_TVALID  <= 1'b1;
                            m_axis_read_package_TDATA   <= {notif_len, notif_sess};
                            state                       <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (m_axis_read_package_TREADY) begin
                        m_axis_read_package_TVALID <= 1'b0;
                        s_axis_rx_metadata_TREADY  <= 1'b1;
                        state                      <= META;
                    end
                end
                META: begin
                    if (s_axis_rx_metadata_TVALID) begin
                        s_axis_rx_metadata_TREADY <= 1'b0;
                        // Mismatch is only flagged; the notified session stays
                        // authoritative for the outgoing beats.
                        if (s_axis_rx_metadata_TDATA != cur_sess)
                            err_flags[0] <= 1'b1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (in_fire) begin
                        if (!s_axis_rx_data_TLAST && s_axis_rx_data_TKEEP != '1)
                            err_flags[1] <= 1'b1;
                        if (s_axis_rx_data_TLAST) begin
                            s_axis_notifications_TREADY <= 1'b1;
                            state                       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry output buffer. The head loads directly from the input
    // whenever it is free or draining, so an accepted beat appears on pkt_tx
    // one cycle later. The skid entry only absorbs the beat accepted while
    // the head was stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_tx_TVALID <= 1'b0;
            pkt_tx_TDATA  <= '0;
            skid_vld      <= 1'b0;
            skid_data     <= '0;
            pkt_count     <= '0;
        end else begin
            if (!pkt_tx_TVALID || pkt_tx_TREADY) begin
                if (skid_vld) begin
                    pkt_tx_TDATA  <= skid_data;
                    pkt_tx_TVALID <= 1'b1;
                    skid_vld      <= 1'b0;
                end else begin
                    pkt_tx_TDATA  <= in_beat;
                    pkt_tx_TVALID <= in_fire;
                end
            end else if (in_fire) begin
                skid_data <= in_beat;
                skid_vld  <= 1'b1;
            end
            if (out_fire && pkt_tx_TDATA[512])
                pkt_count <= pkt_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pkt_receiver.sv
// Scoreboard bench for pkt_receiver: expected read requests and packet beats
// are queued as stimulus is driven and popped when the DUT hands them over.
module tb_pkt_receiver;

    logic         clk = 1'b0;
    logic         rst;
    logic [87:0]  notif_data;
    logic         notif_valid;
    logic         notif_ready;
    logic [31:0]  read_data;
    logic         read_valid;
    logic         read_ready;
    logic [15:0]  meta_data;
    logic         meta_valid;
    logic         meta_ready;
    logic [511:0] rx_data;
    logic [63:0]  rx_keep;
    logic         rx_last;
    logic         rx_valid;
    logic         rx_ready;
    logic [544:0] pkt_data;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [31:0]  pkt_count;
    logic [31:0]  drop_count;
    logic [1:0]   err_flags;

    pkt_receiver dut (
        .clk                         (clk),
        .rst                         (rst),
        .s_axis_notifications_TDATA  (notif_data),
        .s_axis_notifications_TVALID (notif_valid),
        .s_axis_notifications_TREADY (notif_ready),
        .m_axis_read_package_TDATA   (read_data),
        .m_axis_read_package_TVALID  (read_valid),
        .m_axis_read_package_TREADY  (read_ready),
        .s_axis_rx_metadata_TDATA    (meta_data),
        .s_axis_rx_metadata_TVALID   (meta_valid),
        .s_axis_rx_metadata_TREADY   (meta_ready),
        .s_axis_rx_data_TDATA        (rx_data),
        .s_axis_rx_data_TKEEP        (rx_keep),
        .s_axis_rx_data_TLAST        (rx_last),
        .s_axis_rx_data_TVALID       (rx_valid),
        .s_axis_rx_data_TREADY       (rx_ready),
        .pkt_tx_TDATA                (pkt_data),
        .pkt_tx_TVALID               (pkt_valid),
        .pkt_tx_TREADY               (pkt_ready),
        .pkt_count                   (pkt_count),
        .drop_count                  (drop_count),
        .err_flags                   (err_flags)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit tog_mode = 1'b0;

    logic [31:0]  exp_req[$];
    logic [544:0] exp_pkt[$];

    task automatic chk(input string tag, input logic [544:0] act, input logic [544:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Output monitors, sampled mid-cycle where valid/ready are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (read_valid && read_ready) begin
                if (exp_req.size() == 0) chk("read_pkg_unexpected", read_data, 0);
                else chk("read_pkg", read_data, exp_req.pop_front());
            end
            if (pkt_valid && pkt_ready) begin
                if (exp_pkt.size() == 0) chk("pkt_unexpected", pkt_data, 0);
                else chk("pkt_beat", pkt_data, exp_pkt.pop_front());
            end
        end
    end

    // Sink backpressure: toggles every cycle when tog_mode is set.
    always @(posedge clk) begin
        #1;
        if (tog_mode) pkt_ready = ~pkt_ready;
    end

    // Waits for the handshake of the currently valid input channel.
    task automatic wait_hs(input int which, input string tag);
        bit hs = 1'b0;
        int n  = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            case (which)
                0:       hs = notif_ready;
                1:       hs = meta_ready;
                default: hs = rx_ready;
            endcase
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) chk(tag, 0, 1);
    endtask

    task automatic send_notif(input logic [15:0] sess, input logic [15:0] len, input bit closed);
        notif_data        = '0;
        notif_data[15:0]  = sess;
        notif_data[31:16] = len;
        notif_data[80]    = closed;
        notif_valid       = 1'b1;
        if (len != 0 && !closed) exp_req.push_back({len, sess});
        wait_hs(0, "notif_timeout");
        notif_valid = 1'b0;
    endtask

    task automatic send_meta(input logic [15:0] sess);
        meta_data  = sess;
        meta_valid = 1'b1;
        wait_hs(1, "meta_timeout");
        meta_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] len, input logic [15:0] sess,
                             input logic [63:0] keep, input bit last);
        for (int i = 0; i < 16; i++) rx_data[i*32 +: 32] = $urandom();
        rx_keep  = keep;
        rx_last  = last;
        rx_valid = 1'b1;
        exp_pkt.push_back({len, sess, last, rx_data});
        wait_hs(2, "data_timeout");
        rx_valid = 1'b0;
    endtask

    // Full message; bad_idx selects a beat sent with a partial TKEEP (-1: none).
    task automatic send_msg(input logic [15:0] sess, input logic [15:0] meta,
                            input logic [15:0] len, input int beats, input int bad_idx);
        send_notif(sess, len, 1'b0);
        send_meta(meta);
        for (int b = 0; b < beats; b++)
            send_beat(len, sess, (b == bad_idx) ? 64'h0FFF_FFFF_FFFF_FFFF : '1, b == beats - 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_pkt.size() != 0 || exp_req.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_pkt", exp_pkt.size(), 0);
        chk("drain_req", exp_req.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; notif_data = '0; notif_valid = 0; read_ready = 1; meta_data = '0;
        meta_valid = 0; rx_data = '0; rx_keep = '0; rx_last = 0; rx_valid = 0; pkt_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_notif_ready", notif_ready, 0);
        chk("rst_read_valid", read_valid, 0);
        chk("rst_meta_ready", meta_ready, 0);
        chk("rst_data_ready", rx_ready, 0);
        chk("rst_pkt_valid", pkt_valid, 0);
        chk("rst_counts", {pkt_count, drop_count, err_flags}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: basic two-beat message
        send_msg(16'd5, 16'd5, 16'd128, 2, -1);
        drain();
        chk("t1_pkt_count", pkt_count, 1);
        chk("t1_err", err_flags, 0);

        // 2: dropped notifications
        send_notif(16'd3, 16'd0, 1'b0);
        send_notif(16'd4, 16'd64, 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("t2_drop_count", drop_count, 2);
        chk("t2_idle_ready", notif_ready, 1);
        chk("t2_no_req", read_valid, 0);

        // 3: eight beats against toggling sink ready
        tog_mode = 1'b1;
        send_msg(16'h0abc, 16'h0abc, 16'd512, 8, -1);
        drain();
        tog_mode = 1'b0;
        @(posedge clk); #2;
        pkt_ready = 1'b1;
        chk("t3_pkt_count", pkt_count, 2);

        // partial keep on last beat is legal
        send_msg(16'd6, 16'd6, 16'd100, 3, 2);
        drain();
        chk("t5_last_partial_err", err_flags, 0);

        // 4: metadata session mismatch, notified session used downstream
        send_msg(16'd5, 16'd7, 16'd64, 1, -1);
        drain();
        chk("t4_err", err_flags, 2'b01);

        // 5: partial keep on non-last beat
        send_msg(16'd8, 16'd8, 16'd192, 3, 1);
        drain();
        chk("t5_err", err_flags, 2'b11);
        chk("t5_pkt_count", pkt_count, 5);

        // 6: reset in the middle of a message
        send_notif(16'd9, 16'd384, 1'b0);
        send_meta(16'd9);
        send_beat(16'd384, 16'd9, '1, 1'b0);
        send_beat(16'd384, 16'd9, '1, 1'b0);
        rx_valid = 1'b1;
        rst = 1'b1;
        exp_pkt.delete();
        exp_req.delete();
        @(posedge clk);
        @(negedge clk);
        chk("t6_pkt_valid", pkt_valid, 0);
        chk("t6_read_valid", read_valid, 0);
        chk("t6_data_ready", rx_ready, 0);
        chk("t6_counts", {pkt_count, drop_count, err_flags}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rx_valid = 1'b0;
        send_msg(16'd11, 16'd11, 16'd256, 4, -1);
        drain();
        chk("t6_pkt_count", pkt_count, 1);
        chk("t6_err", err_flags, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
